// File: rtl/stage_output_mixer_pkg.sv
// Shared constants and helpers for the operator output pipeline: widths,
// the carrier flag position in the algorithm word, and 16-bit saturation.
package stage_output_mixer_pkg;

  localparam int NUM_OPERATORS_DEF = 128;
  localparam int OP_ID_W           = 7;
  localparam int ALG_W             = 8;
  localparam int ALG_CARRIER_BIT   = 0;
  localparam int MIXER_ACC_WIDTH   = 16 + $clog2(NUM_OPERATORS_DEF);
  localparam int SAT_IN_W          = 40;
  localparam logic [15:0] VOLUME_UNITY = 16'h8000;

  // Clamp a wide signed value into the signed 16-bit audio range.
  function automatic logic signed [15:0] saturate16(input logic signed [SAT_IN_W-1:0] x);
    localparam logic signed [SAT_IN_W-1:0] MaxV = 32767;
    localparam logic signed [SAT_IN_W-1:0] MinV = -32768;
    if (x > MaxV) return 16'sh7FFF;
    if (x < MinV) return -16'sh8000;
    return x[15:0];
  endfunction

endpackage

// File: rtl/stage_output_mixer_sample_output_buffer.sv
// sample_output_buffer: single-entry valid/ready output register; a load over
// an unconsumed sample replaces it and raises a sticky overrun flag.
module sample_output_buffer (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic signed [15:0] data_i,
  input  logic               ready_i,
  output logic signed [15:0] data_o,
  output logic               valid_o,
  output logic               overrun_o
);

  logic signed [15:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
      if (valid_q && !ready_i) overrun_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= 16'sd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/stage_output_mixer.sv
// Final operator-pipeline stage: sums carrier samples per frame, scales,
// saturates and hands one sample per frame to the sink. MIXER_VOLUME_EN adds master volume.
module stage_output_mixer
  import stage_output_mixer_pkg::*;
#(
  parameter int NUM_OPERATORS = NUM_OPERATORS_DEF,
  parameter int CARRIER_BIT   = ALG_CARRIER_BIT,
  parameter int OUTPUT_SHIFT  = 3
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [OP_ID_W-1:0] i_VoiceOperator,
  input  logic [ALG_W-1:0]   i_AlgorithmWord,
  input  logic signed [15:0] i_Waveform,
  input  logic               i_VolumeWriteEnable,
  input  logic [15:0]        i_ConfigWriteData,
  output logic signed [15:0] o_Sample,
  output logic               o_SampleValid,
  input  logic               i_SampleReady,
  output logic               o_Overrun
);

  localparam int ACC_W = 16 + $clog2(NUM_OPERATORS);
  localparam logic [OP_ID_W-1:0] LAST_ID = OP_ID_W'(NUM_OPERATORS - 1);

  logic                    is_first, is_last, carrier;
  logic signed [ACC_W-1:0] contrib;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sync_q, sync_d;
  logic                    vld_p1_q, vld_p1_d;
  logic signed [ACC_W-1:0] acc_shifted;
  logic signed [15:0]      frame_sat;
  logic                    load;
  logic signed [15:0]      load_data;
  logic                    unused_alg;

  assign is_first   = (i_VoiceOperator == '0);
  assign is_last    = (i_VoiceOperator == LAST_ID);
  assign carrier    = i_AlgorithmWord[CARRIER_BIT];
  assign unused_alg = ^i_AlgorithmWord;
  assign contrib    = carrier ? ACC_W'(i_Waveform) : '0;

  // Stage 1: accumulate; ID 0 restarts the sum, the last ID closes a synced frame
  always_comb begin
    acc_d    = is_first ? contrib : acc_q + contrib;
    sync_d   = sync_q | is_first;
    vld_p1_d = is_last & sync_d;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      acc_q    <= '0;
      sync_q   <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sync_q   <= sync_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  // Stage 2: scale and saturate the closed frame sum
  assign acc_shifted = acc_q >>> OUTPUT_SHIFT;
  assign frame_sat   = saturate16(SAT_IN_W'(acc_shifted));

`ifdef MIXER_VOLUME_EN
  logic [15:0]        vol_q, vol_d;
  logic signed [15:0] sat_p2_q;
  logic               vld_p2_q;
  logic signed [32:0] vol_prod;
  logic signed [32:0] vol_scaled;

  assign vol_d = i_VolumeWriteEnable ? i_ConfigWriteData : vol_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      vol_q    <= VOLUME_UNITY;
      vld_p2_q <= 1'b0;
    end else begin
      vol_q    <= vol_d;
      vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge i_Clock) begin
    sat_p2_q <= frame_sat;
  end

  // Stage 3: Q1.15 volume; the unsigned gain is zero-extended before the signed multiply
  assign vol_prod   = 33'(sat_p2_q) * $signed({17'b0, vol_q});
  assign vol_scaled = vol_prod >>> 15;
  assign load       = vld_p2_q;
  assign load_data  = saturate16(SAT_IN_W'(vol_scaled));
`else
  logic unused_cfg;
  assign unused_cfg = ^{i_VolumeWriteEnable, i_ConfigWriteData};
  assign load       = vld_p1_q;
  assign load_data  = frame_sat;
`endif

  sample_output_buffer u_out_buf (
    .clk_i     (i_Clock),
    .rst_i     (i_Reset),
    .load_i    (load),
    .data_i    (load_data),
    .ready_i   (i_SampleReady),
    .data_o    (o_Sample),
    .valid_o   (o_SampleValid),
    .overrun_o (o_Overrun)
  );

endmodule

// File: doc/stage_output_mixer.md
Name: stage_output_mixer

Overview:
- Final stage of the operator pipeline, directly downstream of the envelope attenuator stage.
- Consumes one attenuated operator sample per clock, tagged with operator ID and algorithm word.
- Sums the carrier operators over one full sweep of all operators (one frame), then scales and saturates the sum.
- Presents one signed 16-bit audio sample per frame to the sample sink (DAC/FIFO) over a valid/ready handshake.

Parameters:
NUM_OPERATORS, 128, operators per frame; operator IDs run 0..NUM_OPERATORS-1; must be a power of two
CARRIER_BIT, 0, bit index in the algorithm word that flags the operator as a carrier (1 = summed into the output)
OUTPUT_SHIFT, 3, arithmetic right shift applied to the frame sum before saturation

Ports:
i_Clock  input  1  system clock
i_Reset  input  1  synchronous, active-high reset
i_VoiceOperator  input  `VOICE_OPERATOR_ID  operator ID of the incoming sample
i_AlgorithmWord  input  `ALGORITHM_WORD  algorithm word travelling with the sample
i_Waveform  input  16 signed  attenuated operator sample
i_VolumeWriteEnable  input  1  master volume write strobe (used only with MIXER_VOLUME_EN)
i_ConfigWriteData  input  16  config bus data (used only with MIXER_VOLUME_EN)
o_Sample  output  16 signed  mixed output sample
o_SampleValid  output  1  o_Sample holds an unconsumed sample
i_SampleReady  input  1  sink accepts o_Sample this cycle
o_Overrun  output  1  sticky flag: an unconsumed sample was overwritten

Behaviour:
- Reset behaviour:
  - Synchronous, active-high; overrides everything else in the same cycle.
  - Outputs after reset: o_Sample=0, o_SampleValid=0, o_Overrun=0.
  - Accumulator is cleared and r_FrameSync=0.
- Frame sync:
  - r_FrameSync sets on the first cycle with i_VoiceOperator==0 after reset.
  - No sample is produced until a complete frame (ID 0 through ID NUM_OPERATORS-1) has been seen with r_FrameSync set.
  - A partial frame in progress at reset is discarded.
- Accumulation (cycle 1):
  - Register the inputs.
  - Accumulator width is 16+log2(NUM_OPERATORS) bits, signed (23 bits at default), so it cannot overflow.
  - On ID 0: accumulator = (carrier ? sign-extended sample : 0); any previous sum is discarded.
  - On any other ID: accumulator += (carrier ? sample : 0).
  - Modulator samples (CARRIER_BIT=0) contribute nothing.
- Frame close (cycle 2):
  - Triggered when ID NUM_OPERATORS-1 has been accumulated.
  - Final sum is arithmetic-shifted right by OUTPUT_SHIFT, then saturated to [-32768, 32767].
  - Result loads into o_Sample and o_SampleValid=1.
  - Latency from the last operator's input cycle to o_SampleValid rising is 2 clocks (3 with MIXER_VOLUME_EN).
- Handshake:
  - The sample is consumed on any cycle with o_SampleValid && i_SampleReady; o_SampleValid then drops the next cycle unless a new sample loads in that same cycle.
  - o_Sample is stable while valid and not consumed.
  - If a new sample loads while the previous one is still unconsumed, the new sample replaces it, valid stays 1, and o_Overrun sets.
  - If the load coincides with consumption, there is no overrun; the new sample is presented.
  - o_Overrun clears only on reset.
- Out-of-order IDs: no checking. ID 0 always restarts the sum. Frame close fires only on ID NUM_OPERATORS-1.

Optional Feature:
- Macro MIXER_VOLUME_EN.
- Defined:
  - Adds a 16-bit unsigned master volume register in Q1.15 format; reset value 16'h8000 (unity).
  - Written from i_ConfigWriteData on i_VolumeWriteEnable.
  - The saturated sample is multiplied by the volume and shifted right 15.
  - The product is then re-saturated to 16 bits.
  - This adds one pipeline register, so latency is 3.
  - A volume write takes effect from the next frame close.
- Undefined:
  - No volume register; latency is 2.
  - i_VolumeWriteEnable and i_ConfigWriteData are unused (lint-waived).

Decomposition:
- Shared synth package/header gains:
  - MIXER_ACC_WIDTH constant.
  - CARRIER_BIT index, alongside the existing `ALGORITHM_WORD definition.
  - A saturate16 function shared with other stages.
- One sub-module is natural: sample_output_buffer, the single-entry valid/ready register with overrun detection. It is reusable by future sample sinks.

Test Plan:
- After reset, feed a frame of IDs 0..127 with carrier flag set only on IDs 0 and 4, both samples 1000, SHIFT=3 -> o_Sample=250, o_SampleValid rises 2 cycles after the ID 127 cycle.
- 128 carriers each at 32767 -> sum 4194176 >>3 = 524272, saturates to 32767; same with -32768 -> -32768.
- All modulators (carrier bit 0) with nonzero samples -> o_Sample=0, valid still asserted at frame end.
- Hold i_SampleReady=0 across two frame closes -> second sample replaces first and o_Overrun=1; then ready=1 for one cycle -> valid drops, overrun stays 1.
- Assert i_Reset mid-frame at ID 60 -> outputs zero, no sample for the truncated frame; the first valid sample comes after the next complete 0..127 frame.
- With MIXER_VOLUME_EN, write volume 16'h4000 and use a frame giving 8000 pre-volume -> o_Sample=4000 with latency 3; write 16'hFFFF with pre-volume 30000 -> saturates to 32767.
